// File: rtl/button_pkg.sv
// +--------------------------------------------------------------------+
// | button_pkg : channel state encoding, synchronizer reset level and  |
// |              counter-width helper shared by the button reader.     |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

package button_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } chan_state_e;

   // Pins idle high, so the synchronizer wakes up reading "released".
   localparam logic c_SYNC_RST = 1'b1;

   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// +--------------------------------------------------------------------+
// | debounce_channel : one button - 2-FF synchronizer, debounce FSM,   |
// |                    registered level and press/release/long pulses. |
// | Optional         : BUTTON_LONGPRESS_EN adds the long-hold counter. |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module debounce_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000
) (
   input  logic clk,
   input  logic rstn,
   input  logic btn_n_i,
   output logic pressed_o,
   output logic press_o,
   output logic release_o,
   output logic long_press_o
);

   localparam int              CW        = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
   localparam logic [CW-1:0]   c_DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   c_ONE     = CW'(1);

   logic          sync1_q, sync2_q;
   logic          w_sample;
   chan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pressed_q, pressed_d;
   logic          press_q, press_d;
   logic          release_q, release_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1_q   <= c_SYNC_RST;
         sync2_q   <= c_SYNC_RST;
         state_q   <= IDLE;
         cnt_q     <= '0;
         pressed_q <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= btn_n_i;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign w_sample = ~sync2_q;

   // The terminal compare ends every count, so cnt never wraps.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pressed_d = pressed_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_sample) begin
               state_d = PRESS_WAIT;
               cnt_d   = c_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!w_sample) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == c_DB_LAST) begin
               state_d   = HELD;
               cnt_d     = '0;
               pressed_d = 1'b1;
               press_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + c_ONE;
            end
         end
         HELD: begin
            if (!w_sample) begin
               state_d = RELEASE_WAIT;
               cnt_d   = c_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (w_sample) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == c_DB_LAST) begin
               state_d   = IDLE;
               cnt_d     = '0;
               pressed_d = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + c_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign pressed_o = pressed_q;
   assign press_o   = press_q;
   assign release_o = release_q;

`ifdef BUTTON_LONGPRESS_EN
   localparam logic [CW-1:0] c_LONG_LAST = CW'(LONG_CYCLES - 1);

   logic [CW-1:0] hold_q, hold_d;
   logic          long_q, long_d;
   logic [CW-1:0] w_hold_inc;

   assign w_hold_inc = hold_q + c_ONE;

   // A bounce back from RELEASE_WAIT keeps the count, so one hold gives one pulse.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if ((state_q == PRESS_WAIT) && (state_d == HELD)) begin
         hold_d = '0;
      end else if (state_d == IDLE) begin
         hold_d = '0;
      end else if ((state_q == HELD) && (hold_q != c_LONG_LAST)) begin
         hold_d = w_hold_inc;
         long_d = (w_hold_inc == c_LONG_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_press_o = long_q;
`else
   assign long_press_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/button_reader.sv
// +--------------------------------------------------------------------+
// | button_reader : debounced level and event pulses for NUM_BTN       |
// |                 active-low pushbuttons, one channel per button.    |
// | Optional      : BUTTON_LONGPRESS_EN enables long_press pulses.     |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module button_reader #(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NUM_BTN-1:0] btn_n_i,
   output logic [NUM_BTN-1:0] pressed_o,
   output logic [NUM_BTN-1:0] press_o,
   output logic [NUM_BTN-1:0] release_o,
   output logic [NUM_BTN-1:0] long_press_o
);

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_chan (
         .clk          (clk),
         .rstn         (rstn),
         .btn_n_i      (btn_n_i[g]),
         .pressed_o    (pressed_o[g]),
         .press_o      (press_o[g]),
         .release_o    (release_o[g]),
         .long_press_o (long_press_o[g])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_button_reader.sv
// +--------------------------------------------------------------------+
// | tb_button_reader : directed stimulus with an event scoreboard for  |
// |                    button_reader (BUTTON_LONGPRESS_EN aware).      |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_button_reader;

   localparam int NB = 4;
   localparam int DB = 8;
   localparam int LC = 20;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic [NB-1:0] btn_n = '1;
   logic [NB-1:0] pressed, press, rel, lp;

   button_reader #(
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (DB),
      .LONG_CYCLES     (LC)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .btn_n_i      (btn_n),
      .pressed_o    (pressed),
      .press_o      (press),
      .release_o    (rel),
      .long_press_o (lp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            at;
      logic [NB-1:0] p;
      logic [NB-1:0] r;
      logic [NB-1:0] l;
   } exp_t;

   exp_t q[$];
   exp_t e_mon;
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
      end
   endtask

   task automatic push(input int at, input logic [NB-1:0] p, input logic [NB-1:0] r,
                       input logic [NB-1:0] l);
      exp_t e;
      e.at = at; e.p = p; e.r = r; e.l = l;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every edge with a pulse must match the head of the queue.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         while (q.size() > 0 && q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse cyc=%0d actual=none required=p%b r%b l%b at %0d",
                     cyc, q[0].p, q[0].r, q[0].l, q[0].at);
            void'(q.pop_front());
         end
         if ((press | rel | lp) != '0) begin
            if (q.size() > 0 && q[0].at == cyc) begin
               e_mon = q.pop_front();
               chk("press_pulse",   press, e_mon.p);
               chk("release_pulse", rel,   e_mon.r);
               chk("long_pulse",    lp,    e_mon.l);
            end else begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse cyc=%0d actual=p%b r%b l%b required=none",
                        cyc, press, rel, lp);
            end
         end
      end
   end

   initial begin
      // Reset with all buttons released
      rstn  = 1'b0;
      btn_n = '1;
      step(3);
      chk("reset_pressed", pressed, '0);
      chk("reset_pulses", press | rel | lp, '0);
      rstn = 1'b1;
      step(50);
      chk("idle_pressed", pressed, '0);

      // Clean press on button 0
      btn_n[0] = 1'b0;
      push(cyc + 10, 4'b0001, 4'b0000, 4'b0000);
      step(10);
      chk("press0_level", pressed, 4'b0001);
      step(1);
      chk("press0_one_cycle", press, 4'b0000);
      btn_n[0] = 1'b1;
      push(cyc + 10, 4'b0000, 4'b0001, 4'b0000);
      step(12);
      chk("release0_level", pressed, 4'b0000);

      // Bounce on button 1: 5 low, 2 high, then steady low
      btn_n[1] = 1'b0;
      step(5);
      btn_n[1] = 1'b1;
      step(2);
      btn_n[1] = 1'b0;
      push(cyc + 10, 4'b0010, 4'b0000, 4'b0000);
      step(9);
      chk("bounce1_not_yet", pressed, 4'b0000);
      step(3);
      chk("bounce1_level", pressed, 4'b0010);
      btn_n[1] = 1'b1;
      push(cyc + 10, 4'b0000, 4'b0010, 4'b0000);
      step(12);

      // Buttons 2 and 3 together
      btn_n[3:2] = 2'b00;
      push(cyc + 10, 4'b1100, 4'b0000, 4'b0000);
      step(12);
      chk("press23_level", pressed, 4'b1100);
      btn_n[3:2] = 2'b11;
      push(cyc + 10, 4'b0000, 4'b1100, 4'b0000);
      step(10);
      chk("release23_level", pressed, 4'b0000);
      step(2);

      // Reset mid-debounce with button 0 held through it
      btn_n[0] = 1'b0;
      step(5);
      rstn = 1'b0;
      step(1);
      chk("midreset_pressed", pressed, '0);
      chk("midreset_pulses", press | rel | lp, '0);
      rstn = 1'b1;
      push(cyc + 10, 4'b0001, 4'b0000, 4'b0000);
      step(9);
      chk("midreset_not_yet", pressed, 4'b0000);
      step(3);
      chk("midreset_level", pressed, 4'b0001);
      btn_n[0] = 1'b1;
      push(cyc + 10, 4'b0000, 4'b0001, 4'b0000);
      step(12);

      // Long hold on button 2
      btn_n[2] = 1'b0;
      push(cyc + 10, 4'b0100, 4'b0000, 4'b0000);
`ifdef BUTTON_LONGPRESS_EN
      push(cyc + 10 + LC - 1, 4'b0000, 4'b0000, 4'b0100);
`endif
      step(50);
      chk("long2_level", pressed, 4'b0100);
      btn_n[2] = 1'b1;
      push(cyc + 10, 4'b0000, 4'b0100, 4'b0000);
      step(12);
      chk("final_level", pressed, 4'b0000);

      step(20);
      while (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL leftover_expect actual=none required=p%b r%b l%b at %0d",
                  q[0].p, q[0].r, q[0].l, q[0].at);
         void'(q.pop_front());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
